// File: rtl/cla_add_seq.sv
// cla_add_seq: multi-cycle adder/subtractor built around one shared 4-bit
// carry-look-ahead slice. One nibble is resolved per clock, LSB first, so a
// WIDTH-bit operation takes WIDTH/4 cycles and finishes with a one-cycle
// done pulse.
module cla_add_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / 4;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One 4-bit look-ahead slice; returns {carry_out, carry_into_bit3, sum}.
  // The carry into bit 3 is kept because on the top slice it is the carry
  // into the sign bit, needed for the overflow flag.
  function automatic logic [5:0] cla4(input logic [3:0] x,
                                      input logic [3:0] y,
                                      input logic       cin);
    logic [3:0] g;
    logic [3:0] p;
    logic       c1, c2, c3, c4;
    g  = x & y;
    p  = x | y;
    c1 = g[0] | (p[0] & cin);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & cin);
    return {c4, c3, (x ^ y ^ {c3, c2, c1, cin})};
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            carry_q, carry_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic            co_q, co_d;
  logic            ovf_q, ovf_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic            sub_q, sub_d;
  logic            ci_q, ci_d;

  logic [CW+1:0]   nib_idx;
  logic [3:0]      a_nib;
  logic [3:0]      b_nib;
  logic            slice_cin;
  logic [5:0]      slice_res;

  // Select the active nibble and evaluate the shared slice; subtract is
  // a + ~b + 1, so b is inverted and slice 0 gets a forced carry-in.
  always_comb begin
    nib_idx   = {cnt_q, 2'b00};
    a_nib     = a_q[nib_idx +: 4];
    b_nib     = sub_q ? ~b_q[nib_idx +: 4] : b_q[nib_idx +: 4];
    slice_cin = (cnt_q == '0) ? (sub_q | ci_q) : carry_q;
    if (cnt_q == '0 && !sub_q) slice_cin = ci_q;
    slice_res = cla4(a_nib, b_nib, slice_cin);
  end

  // Next-state, counter and result updates; start is only honoured outside RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    s_d     = s_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    ci_d    = ci_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          carry_d = 1'b0;
          a_d     = a;
          b_d     = b;
          sub_d   = op_sub;
          ci_d    = ci;
        end
      end
      RUN: begin
        s_d[nib_idx +: 4] = slice_res[3:0];
        carry_d           = slice_res[5];
        if (cnt_q == LAST) begin
          co_d    = slice_res[5];
          ovf_d   = slice_res[4] ^ slice_res[5];
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Control state and visible results, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  // Latched operands; only meaningful after a start, so no reset needed.
  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    sub_q <= sub_d;
    ci_q  <= ci_d;
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign s    = s_q;
  assign co   = co_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_cla_add_seq.sv
// Testbench for cla_add_seq (WIDTH=32): directed vectors, scoreboard queue
// filled by the driver, drained by a monitor on every done pulse.
module tb_cla_add_seq;

  localparam int WIDTH  = 32;
  localparam int NSLICE = WIDTH / 4;

  logic             clk;
  logic             reset_n;
  logic             start;
  logic             op_sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;

  cla_add_seq #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op_sub  (op_sub),
    .a       (a),
    .b       (b),
    .ci      (ci),
    .busy    (busy),
    .done    (done),
    .s       (s),
    .co      (co),
    .ovf     (ovf)
  );

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;
    int               t;
  } exp_t;

  exp_t exp_q[$];
  int   tests   = 0;
  int   fails   = 0;
  int   cyc     = 0;
  int   pushed  = 0;
  int   dones   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n && done) begin
      exp_t e;
      dones++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        e = exp_q.pop_front();
        check("result_s", 64'(s), 64'(e.s));
        check("result_co", 64'(co), 64'(e.co));
        check("result_ovf", 64'(ovf), 64'(e.ovf));
        check("latency", 64'(cyc - e.t), 64'(NSLICE));
        check("busy_in_done", 64'(busy), 64'd0);
      end
    end
  end

  // Caller positions time just before the edge that should sample start.
  task automatic issue(input logic sub, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input logic civ, input logic [WIDTH-1:0] es, input logic eco,
                       input logic eovf, input bit push);
    exp_t e;
    op_sub = sub;
    a      = av;
    b      = bv;
    ci     = civ;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    if (push) begin
      e.s = es; e.co = eco; e.ovf = eovf; e.t = cyc;
      exp_q.push_back(e);
      pushed++;
    end
  endtask

  // Returns at the falling edge of the done cycle, or flags a timeout.
  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done expected done within 30 cycles");
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    op_sub  = 1'b0;
    a       = '0;
    b       = '0;
    ci      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_s", 64'(s), 64'd0);
    check("reset_co", 64'(co), 64'd0);
    check("reset_ovf", 64'(ovf), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic add/sub vectors
    @(negedge clk);
    issue(1'b0, 32'h00000001, 32'hFFFFFFFF, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
    wait_done();
    @(negedge clk);
    issue(1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b1);
    wait_done();
    @(negedge clk);
    issue(1'b1, 32'h00000005, 32'h00000007, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1);
    wait_done();
    @(negedge clk);
    issue(1'b1, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b1);
    wait_done();
    @(negedge clk);
    issue(1'b0, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1);
    wait_done();
    @(negedge clk);
    issue(1'b1, 32'h00001234, 32'h00001234, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1);
    wait_done();
    @(negedge clk);
    issue(1'b1, 32'h00000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b1);
    wait_done();

    // Start during RUN beat 2 must be ignored
    @(negedge clk);
    issue(1'b0, 32'h00000003, 32'h00000004, 1'b0, 32'h00000007, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; ci = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);

    // Reset asserted during RUN beat 4: outputs cleared, no done
    issue(1'b0, 32'h11111111, 32'h22222222, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_s", 64'(s), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_co_ovf", 64'({co, ovf}), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    issue(1'b0, 32'h00000010, 32'h00000020, 1'b0, 32'h00000030, 1'b0, 1'b0, 1'b1);
    wait_done();

    // Back-to-back: new start issued in the DONE cycle
    @(negedge clk);
    issue(1'b0, 32'h0000000F, 32'h00000001, 1'b0, 32'h00000010, 1'b0, 1'b0, 1'b1);
    wait_done();
    issue(1'b0, 32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0, 1'b0, 1'b1);
    wait_done();

    repeat (12) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("done_count", 64'(dones), 64'(pushed));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cla_add_seq.md
CLA_ADD_SEQ -- requirements
Module: cla_add_seq

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand width in bits; legal values are multiples of 4 from 8 to 64.
REQ-002 SHALL derive the local constant NSLICE = WIDTH/4, the number of 4-bit carry-look-ahead beats per operation.
REQ-003 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port: reset_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port: start  input  1  request pulse; sampled only when the block is not busy.
REQ-006 SHALL have port: op_sub  input  1  operation select: 0 = a+b+ci, 1 = a-b.
REQ-007 SHALL have port: a  input  WIDTH  operand A.
REQ-008 SHALL have port: b  input  WIDTH  operand B.
REQ-009 SHALL have port: ci  input  1  carry-in; used only for add.
REQ-010 SHALL have port: busy  output  1  high while an operation is in progress.
REQ-011 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port: s  output  WIDTH  sum or difference result.
REQ-013 SHALL have port: co  output  1  carry-out of the MSB; for subtract, 1 means no borrow.
REQ-014 SHALL have port: ovf  output  1  signed two's-complement overflow.

Function
REQ-015 SHALL implement an FSM with three states: IDLE, RUN and DONE.
REQ-016 SHALL accept start only in IDLE or DONE; on acceptance SHALL latch a, b, op_sub and ci, clear the slice counter, go to RUN and drive busy=1 from the next cycle.
REQ-017 SHALL ignore start while in RUN; latched operands and the result in progress SHALL be unaffected.
REQ-018 SHALL use a single shared 4-bit CLA slice in RUN (g=a&b, p=a|b, 4-bit look-ahead carry equations); each cycle it processes the slice selected by the counter, LSB slice first.
REQ-019 SHALL write each slice's 4-bit sum into the matching nibble of s and hold the slice carry-out in a carry register that feeds the next beat.
REQ-020 SHALL take the carry into slice 0 from latched ci for add; for subtract it SHALL force carry-in to 1 and use ~b in place of b.
REQ-021 SHALL, on the last beat (counter = NSLICE-1), set co to the slice carry-out and ovf to (carry into bit WIDTH-1) XOR (carry-out), then go to DONE.
REQ-022 SHALL have a latency of exactly NSLICE cycles: if start is sampled at edge T, done=1 during the cycle after edge T+NSLICE (8 cycles for WIDTH=32).
REQ-023 SHALL assert done for exactly one cycle in DONE and drive busy=0 in DONE.
REQ-024 SHALL leave DONE for IDLE after one cycle, or for RUN if start is asserted in DONE (back-to-back operation with no idle gap).
REQ-025 SHALL hold s, co and ovf stable from the done pulse until the next accepted start; on that start they MAY be overwritten beat by beat.
REQ-026 SHALL wrap the counter only through the FSM: the counter SHALL never exceed NSLICE-1 and SHALL reset to 0 on every accepted start.

Reset
REQ-027 SHALL, when reset_n is low, immediately and asynchronously force state=IDLE, counter=0, carry register=0, busy=0, done=0, s=0, co=0 and ovf=0, regardless of clk.
REQ-028 SHALL, when reset asserts mid-operation, abandon the operation without a done pulse; the first start after release SHALL complete normally.

Verification
REQ-029 SHALL pass: add a=0x00000001, b=0xFFFFFFFF, ci=0 -> s=0x00000000, co=1, ovf=0, done exactly 8 cycles after the start edge.
REQ-030 SHALL pass: add a=0x7FFFFFFF, b=0x00000001, ci=0 -> s=0x80000000, co=0, ovf=1.
REQ-031 SHALL pass: subtract a=5, b=7 (ci=0, ignored) -> s=0xFFFFFFFE, co=0, ovf=0; subtract a=0x80000000, b=1 -> s=0x7FFFFFFF, co=1, ovf=1.
REQ-032 SHALL pass: start a=3, b=4; at RUN beat 2 pulse start with a=b=0xFFFFFFFF -> the pulse is ignored, s=0x00000007, and exactly one done pulse occurs.
REQ-033 SHALL pass: reset_n driven low during RUN beat 4 -> all outputs 0 within the same cycle and no done pulse; after release, 0x10+0x20 -> s=0x30.
REQ-034 SHALL pass: start asserted in the DONE cycle with new operands -> busy=1 the next cycle, second done pulse 8 cycles later, first result valid during the first done pulse.
